// File: rtl/alu_tile_ingress_scheduler.sv
// Per-channel ingress FIFOs (N,E,S,W,host) feeding a round-robin issue register toward one ALU tile.
// Latency: 2 cycles from input to issue. Upstream is never stalled (a full FIFO drops and counts); ALU stall freezes the issue register.
module alu_tile_ingress_scheduler #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5*DATA_W-1:0]   in_a,
  input  logic [5*DATA_W-1:0]   in_b,
  input  logic [5*CTRL_W-1:0]   in_ctrl,
  input  logic [4:0]            in_valid,
  output logic [4:0]            fifo_full,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [CTRL_W-1:0]     alu_ctrl,
  output logic [2:0]            alu_src,
  output logic                  alu_valid,
  input  logic                  alu_ready,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic                  drop_sticky
);
  localparam int NCH = 5;
  localparam int AW  = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [CTRL_W-1:0] ctrl;
  } flit_t;

  flit_t            mem_q    [NCH][DEPTH];
  flit_t            mem_d    [NCH][DEPTH];
  logic [AW:0]      wr_ptr_q [NCH];
  logic [AW:0]      wr_ptr_d [NCH];
  logic [AW:0]      rd_ptr_q [NCH];
  logic [AW:0]      rd_ptr_d [NCH];
  logic [NCH-1:0]   full_q, full_d;
  flit_t            issue_q, issue_d;
  logic [2:0]       src_q, src_d;
  logic             vld_q, vld_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;

  flit_t            in_flit [NCH];
  logic [NCH-1:0]   empty, push, drop, pop;
  logic             adv, grant_vld;
  logic [2:0]       grant;
  logic [3:0]       cand;
  logic [2:0]       ndrop;
  logic [CNT_W:0]   cnt_sum;

  // Push decisions use the registered full flag, so a simultaneous pop never rescues a push.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      in_flit[i].a    = in_a[i*DATA_W +: DATA_W];
      in_flit[i].b    = in_b[i*DATA_W +: DATA_W];
      in_flit[i].ctrl = in_ctrl[i*CTRL_W +: CTRL_W];
      empty[i]        = (wr_ptr_q[i] == rd_ptr_q[i]);
      push[i]         = in_valid[i] & ~full_q[i];
      drop[i]         = in_valid[i] & full_q[i];
    end
  end

  always_comb begin
    adv       = ~vld_q | alu_ready;
    grant_vld = 1'b0;
    grant     = 3'd0;
    cand      = 4'd0;
    for (int k = 0; k < NCH; k++) begin
      cand = {1'b0, ptr_q} + 4'(k);
      if (cand >= 4'(NCH)) cand = cand - 4'(NCH);
      if (!grant_vld && !empty[cand[2:0]]) begin
        grant_vld = 1'b1;
        grant     = cand[2:0];
      end
    end
    pop = '0;
    if (adv && grant_vld) pop[grant] = 1'b1;
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NCH; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + {{AW{1'b0}}, push[i]};
      rd_ptr_d[i] = rd_ptr_q[i] + {{AW{1'b0}}, pop[i]};
      full_d[i]   = (wr_ptr_d[i][AW] != rd_ptr_d[i][AW]) &&
                    (wr_ptr_d[i][AW-1:0] == rd_ptr_d[i][AW-1:0]);
      if (push[i]) mem_d[i][wr_ptr_q[i][AW-1:0]] = in_flit[i];
    end
  end

  // Data fields hold their last value when nothing is granted.
  always_comb begin
    issue_d = issue_q;
    src_d   = src_q;
    vld_d   = vld_q;
    ptr_d   = ptr_q;
    if (adv) begin
      vld_d = grant_vld;
      if (grant_vld) begin
        issue_d = mem_q[grant][rd_ptr_q[grant][AW-1:0]];
        src_d   = grant;
        ptr_d   = (grant == 3'd4) ? 3'd0 : grant + 3'd1;
      end
    end
  end

  always_comb begin
    ndrop = 3'd0;
    for (int i = 0; i < NCH; i++) ndrop = ndrop + {2'b00, drop[i]};
    cnt_sum  = {1'b0, cnt_q} + {{(CNT_W-2){1'b0}}, ndrop};
    cnt_d    = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    sticky_d = sticky_q | (ndrop != 3'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      full_q   <= '0;
      issue_q  <= '0;
      src_q    <= '0;
      vld_q    <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      issue_q  <= issue_d;
      src_q    <= src_d;
      vld_q    <= vld_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign fifo_full   = full_q;
  assign alu_a       = issue_q.a;
  assign alu_b       = issue_q.b;
  assign alu_ctrl    = issue_q.ctrl;
  assign alu_src     = src_q;
  assign alu_valid   = vld_q;
  assign drop_cnt    = cnt_q;
  assign drop_sticky = sticky_q;

endmodule

// File: doc/alu_tile_ingress_scheduler.md
Name: alu_tile_ingress_scheduler

Overview:
- Sits in front of one ALU tile's compute core.
- Buffers operand flits arriving on the five tile ingress channels: N, E, S, W and host.
- Arbitrates among the buffered flits round-robin and issues at most one (a, b, ctrl) operation per cycle to the ALU over a valid/ready interface.
- Upstream links are valid-only, so per-channel FIFOs absorb bursts, and overflow is counted rather than back-pressured.

Parameters:
- DATA_W, 64, width of operands a and b.
- CTRL_W, 16, width of the ctrl field.
- DEPTH, 4, entries per ingress FIFO. Power of two, minimum 2.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- in_a  in  5*DATA_W  operand a per channel. Slice i: 0=N, 1=E, 2=S, 3=W, 4=host.
- in_b  in  5*DATA_W  operand b per channel.
- in_ctrl  in  5*CTRL_W  ctrl per channel.
- in_valid  in  5  flit-present strobe per channel.
- fifo_full  out  5  registered; bit i high when FIFO i holds DEPTH entries.
- alu_a  out  DATA_W  issued operand a.
- alu_b  out  DATA_W  issued operand b.
- alu_ctrl  out  CTRL_W  issued ctrl.
- alu_src  out  3  channel index (0..4) of the issued flit.
- alu_valid  out  1  issue valid.
- alu_ready  in  1  ALU accepts the issue this cycle.
- drop_cnt  out  CNT_W  saturating count of dropped flits.
- drop_sticky  out  1  set on any drop; cleared only by reset.

Behaviour:
- Reset (async assert, sync release):
  - All FIFOs empty, fifo_full=0.
  - alu_valid=0; alu_a, alu_b, alu_ctrl, alu_src=0.
  - drop_cnt=0, drop_sticky=0.
  - RR pointer=0, so N has highest priority.
  - Reset asserted mid-operation discards all buffered and in-flight flits immediately.
- Push:
  - On each posedge, channel i with in_valid[i]=1 writes into FIFO i if fifo_full[i]=0 (the registered value).
  - Otherwise the flit is dropped.
  - A push onto a full FIFO is dropped even if the same FIFO pops in that cycle. This behaviour is deterministic and intentional.
- Drop accounting:
  - drop_cnt adds the number of channels dropping that cycle (0..5) and saturates at 2^CNT_W-1.
  - drop_sticky sets whenever that number is >0.
- Pointers: read and write pointers carry one extra wrap bit. Full = pointers equal except for the MSB; empty = pointers fully equal. Wrap-around is modulo DEPTH.
- Issue register advance: the register advances when alu_valid=0 or alu_ready=1 ("adv").
  - When alu_valid=1 and alu_ready=0, all alu_* outputs hold stable with no change.
  - No FIFO pops during a stall.
- Arbitration, evaluated when adv=1:
  - Candidates are the non-empty FIFOs.
  - Search from index ptr upward, wrapping 4→0, and grant the first candidate g.
  - Pop FIFO g; load alu_a, alu_b, alu_ctrl from its head, alu_src=g, alu_valid=1.
  - Update ptr=(g+1) mod 5.
  - With no candidates: alu_valid=0, data outputs keep their last values, ptr unchanged.
- Simultaneous push and pop on the same non-full FIFO: both occur and the count is unchanged. A pop and a push on an empty FIFO cannot coincide, because a popped entry must already be present.
- Latency:
  - A flit sampled at edge E0 into an empty, uncontended scheduler appears with alu_valid=1 after edge E1.
  - The minimum is 2 cycles input-to-issue.
  - Throughput is one issue per cycle while alu_ready=1.
- Ordering: per-channel FIFO order is preserved. There is no ordering guarantee across channels.
- Fairness: each non-empty channel is granted within 5 issues.

Test Plan:
- Single flit:
  - Stimulus: reset, then N valid for 1 cycle with a=0x5, b=0x3, ctrl=0x0001, alu_ready=1.
  - Expect: alu_valid high exactly one cycle, 2 cycles after the push, with alu_a=5, alu_b=3, alu_ctrl=1, alu_src=0.
- Round-robin:
  - Stimulus: all 5 channels valid for one cycle, a=i on channel i.
  - Expect: issues in order src 0,1,2,3,4 on consecutive cycles.
  - Then push on channels 4 and 1 together. Expect src 1 first (ptr=0), then 4.
- Back-pressure:
  - Stimulus: hold alu_ready=0 with a flit issued, then push 4 more E flits, a=10..13.
  - Expect: outputs frozen; fifo_full[1]=1 after the 4th push.
  - Then release alu_ready. Expect E flits issued in order 10,11,12,13.
- Overflow:
  - Stimulus: with FIFO W full and alu_ready=0, push W and S on the same cycle with S also full.
  - Expect: drop_cnt increments by 2, drop_sticky=1, and FIFO contents are unchanged.
- Saturation (CNT_W=4 build):
  - Stimulus: force 20 drops.
  - Expect: drop_cnt=15 and held there.
- Reset mid-stream:
  - Stimulus: assert rst while 3 flits are buffered and alu_valid=1.
  - Expect: alu_valid=0, fifo_full=0 and drop_cnt=0 immediately (asynchronously).
  - After release: no stale flit is ever issued.
